// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC dot-product block.
// Build option: MAC_SATURATE_EN selects a clamping accumulator.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/MultiplierNbit.sv
// Combinational unsigned N x N multiplier.
// Feeds the product register of mac_dot_product.
module MultiplierNbit #(
  parameter int N = 6
) (
  input  logic [N-1:0]   m,
  input  logic [N-1:0]   q,
  output logic [2*N-1:0] P
);

  logic [2*N-1:0] pp [N];
  logic [2*N-1:0] acc;

  // Shift-and-add over the multiplier bits.
  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      pp[i] = q[i] ? ({{N{1'b0}}, m} << i) : '0;
      acc   = acc + pp[i];
    end
  end

  assign P = acc;

endmodule

// File: rtl/mac_dot_product.sv
// Streaming dot product: LEN (m,q) pairs in, one sum out.
// Build option: MAC_SATURATE_EN clamps on overflow instead of wrapping.
module mac_dot_product
  import mac_pkg::*;
#(
  parameter int N     = 6,
  parameter int LEN   = 8,
  parameter int ACC_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     m,
  input  logic [N-1:0]     q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             overflow
);

  localparam int CW = clog2(LEN + 1);
  localparam int PW = 2 * N;
  localparam int SW = ACC_W + 1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    p_q;
  logic             pv_q;
  logic [PW-1:0]    prod;
  logic [SW-1:0]    sum;
  logic             accept;
  logic             last;

  MultiplierNbit #(.N(N)) u_mult (
    .m (m),
    .q (q),
    .P (prod)
  );

  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = out_valid ? acc_q : '0;
  assign overflow  = ovf_q;

  assign accept = in_valid && in_ready && !clear;
  assign last   = (cnt_q == CW'(LEN - 1));
  assign sum    = SW'(acc_q) + SW'(p_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (pv_q) begin
      acc_d = sum[ACC_W-1:0];
      if (sum[ACC_W]) begin
        ovf_d = 1'b1;
`ifdef MAC_SATURATE_EN
        acc_d = '1;
`endif
      end
    end

    unique case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase

    // Abort wins over every in-flight update.
    if (clear) begin
      state_d = ST_ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      p_q     <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      pv_q    <= accept;
      if (accept) p_q <= prod;
    end
  end

endmodule

// File: tb/tb_mac_dot_product.sv
// Scoreboard bench for mac_dot_product at ACC_W=15 and ACC_W=12.
// Honours MAC_SATURATE_EN when building the expected sums.
module tb_mac_dot_product;

  localparam int N   = 6;
  localparam int LEN = 8;
  localparam int AW  = 15;
  localparam int AW2 = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [N-1:0] m = '0;
  logic [N-1:0] q = '0;

  logic           rdy_a, vld_a, ovf_a;
  logic [AW-1:0]  dat_a;
  logic           rdy_b, vld_b, ovf_b;
  logic [AW2-1:0] dat_b;

  mac_dot_product #(.N(N), .LEN(LEN), .ACC_W(AW)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy_a),
    .m(m), .q(q),
    .out_valid(vld_a), .out_ready(out_ready),
    .out_data(dat_a), .overflow(ovf_a)
  );

  mac_dot_product #(.N(N), .LEN(LEN), .ACC_W(AW2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy_b),
    .m(m), .q(q),
    .out_valid(vld_b), .out_ready(out_ready),
    .out_data(dat_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint d;
    bit     o;
  } exp_t;

  exp_t   sb_a[$];
  exp_t   sb_b[$];
  longint terms[$];
  int     tests = 0;
  int     fails = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic exp_t model(input int w);
    exp_t   e;
    longint tot;
    longint lim;
    tot = 0;
    foreach (terms[i]) tot += terms[i];
    lim = longint'(1) << w;
    e.o = (tot >= lim);
`ifdef MAC_SATURATE_EN
    e.d = e.o ? lim - 1 : tot;
`else
    e.d = tot % lim;
`endif
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_ready) begin
      if (vld_a) begin
        if (sb_a.size() == 0) begin
          chk("unexpected_a", 1, 0);
        end else begin
          e = sb_a.pop_front();
          chk("data_a", longint'(dat_a), e.d);
          chk("ovf_a", longint'(ovf_a), longint'(e.o));
        end
      end
      if (vld_b) begin
        if (sb_b.size() == 0) begin
          chk("unexpected_b", 1, 0);
        end else begin
          e = sb_b.pop_front();
          chk("data_b", longint'(dat_b), e.d);
          chk("ovf_b", longint'(ovf_b), longint'(e.o));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input int mv, input int qv);
    int k;
    m = N'(mv);
    q = N'(qv);
    in_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rdy_a) break;
    end
    if (k == 200) begin
      $display("FAIL in_ready_timeout: got 0 expected 1");
      $fatal(1, "in_ready never rose");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    terms.push_back(longint'(mv * qv));
    if (terms.size() == LEN) begin
      sb_a.push_back(model(AW));
      sb_b.push_back(model(AW2));
      terms.delete();
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (vld_a) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    bit     ok;
    longint d0;

    repeat (2) @(negedge clk);
    chk("rst_valid", longint'(vld_a), 0);
    chk("rst_data", longint'(dat_a), 0);
    chk("rst_ovf", longint'(ovf_a), 0);
    chk("rst_ready", longint'(rdy_a), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: constant beats, latency and single-cycle valid
    for (int i = 0; i < LEN; i++) beat(3, 5);
    @(negedge clk);
    chk("lat_flush_valid", longint'(vld_a), 0);
    chk("lat_flush_ready", longint'(rdy_a), 0);
    @(negedge clk);
    chk("lat_done_valid", longint'(vld_a), 1);
    chk("lat_done_data", longint'(dat_a), 120);
    @(negedge clk);
    chk("one_cycle_valid", longint'(vld_a), 0);
    chk("ready_after_hand", longint'(rdy_a), 1);
    idle(1);

    // 2: full-scale operands
    for (int i = 0; i < LEN; i++) beat(63, 63);
    idle(4);

    // 3: backpressure
    out_ready = 1'b0;
    for (int i = 0; i < LEN; i++)
      beat(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    wait_valid(ok);
    d0 = longint'(dat_a);
    if (sb_a.size() != 0) chk("bp_first", d0, sb_a[0].d);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", longint'(vld_a), 1);
      chk("bp_data", longint'(dat_a), d0);
      chk("bp_ready", longint'(rdy_a), 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_ready", longint'(rdy_a), 1);
    chk("bp_release_valid", longint'(vld_a), 0);
    idle(1);

    // 4: gappy input
    for (int i = 1; i <= LEN; i++) begin
      beat(i, 1);
      idle(int'($urandom_range(0, 3)));
    end
    idle(4);

    // 5: clear drops partial sum and a beat offered alongside it
    for (int i = 0; i < 4; i++) beat(10, 10);
    clear = 1'b1;
    in_valid = 1'b1;
    m = 6'd20;
    q = 6'd20;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    terms.delete();
    for (int i = 0; i < LEN; i++) beat(1, 2);
    idle(4);

    // 6: asynchronous reset mid-sum
    for (int i = 0; i < 3; i++) beat(7, 9);
    rst_n = 1'b0;
    terms.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mid_valid", longint'(vld_a), 0);
      chk("rst_mid_data", longint'(dat_a), 0);
      chk("rst_mid_ovf", longint'(ovf_a), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < LEN; i++) beat(2, 2);
    idle(4);

    // randomized sums with gaps
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < LEN; i++) begin
        beat(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      end
    end

    for (int k = 0; k < 50; k++) begin
      if (sb_a.size() == 0 && sb_b.size() == 0) break;
      @(posedge clk);
    end
    idle(2);
    chk("drain", longint'(sb_a.size() + sb_b.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
